// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bus master.
// Holds the FSM state encoding, target select codes, address field widths
// and a helper that packs the address-phase word.
package dma_pkg;

    localparam int ADDR_SEL_W  = 3;
    localparam int WORD_ADDR_W = 29;

    localparam logic [ADDR_SEL_W-1:0] DEV_MEM = 3'b010;
    localparam logic [ADDR_SEL_W-1:0] DEV_IO  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_RD_END  = 3'd3,
        ST_WR_ADDR = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_END  = 3'd6,
        ST_DONE    = 3'd7
    } dma_state_t;

    // Address phase layout: word address above the target select code.
    function automatic logic [31:0] addr_phase(input logic [WORD_ADDR_W-1:0] word,
                                               input logic [ADDR_SEL_W-1:0]  sel);
        return {word, sel};
    endfunction

endpackage

// File: rtl/dma_bus_master_if.sv
// Frame/Ready/read/write/Address group of the shared bus.
// Data is carried as a plain inout on the master so the tristate resolves
// at the level where the targets are attached.
//   master : drives all signals
//   slave  : observes all signals
interface dma_bus_master_if;
    logic        Frame;
    logic        Ready;
    logic        read;
    logic        write;
    logic [31:0] Address;

    modport master (output Frame, Ready, read, write, Address);
    modport slave  (input  Frame, Ready, read, write, Address);
endinterface

// File: rtl/dma_stage_buf.sv
// Staging buffer for one burst: DEPTH x 32 register file with independent
// write and read pointers. clr rewinds both pointers at the start of a burst.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : rewind both pointers
//   wr_en/wr_data: store a word at the write pointer
//   rd_en/rd_data: rd_data shows the word at the read pointer; rd_en advances it
module dma_stage_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dma_bus_master.sv
// DMA bus master: copies count 32-bit words from {src_sel, src_word} to
// {dst_sel, dst_word} as alternating read/write bursts of up to BUF_DEPTH words.
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a transfer (sampled only in IDLE)
//   src_sel/src_word   : source target code and start word address
//   dst_sel/dst_word   : destination target code and start word address
//   count              : number of words
//   busy, done         : transfer in progress / one-cycle completion pulse
//   bus                : Frame, Ready, read, write, Address (master modport)
//   Data               : bidirectional data, driven only in WR_DATA
// Optional: define DMA_CHECKSUM_EN to add checksum, the wrap-around sum of
// every word written.
//
// state    | meaning
// IDLE     | waiting for start
// RD_ADDR  | read address phase
// RD_DATA  | read beats, capture lags the bus by one cycle
// RD_END   | capture last word, bus turnaround
// WR_ADDR  | write address phase
// WR_DATA  | write beats from the staging buffer
// WR_END   | advance addresses and remaining count
// DONE     | completion pulse
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_SEL_W-1:0]  src_sel,
    input  logic [WORD_ADDR_W-1:0] src_word,
    input  logic [ADDR_SEL_W-1:0]  dst_sel,
    input  logic [WORD_ADDR_W-1:0] dst_word,
    input  logic [LEN_W-1:0]       count,
    output logic                   busy,
    output logic                   done,
`ifdef DMA_CHECKSUM_EN
    output logic [31:0]            checksum,
`endif
    dma_bus_master_if.master       bus,
    inout  wire  [31:0]            Data
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    dma_state_t             state;
    logic [ADDR_SEL_W-1:0]  src_sel_q, dst_sel_q;
    logic [WORD_ADDR_W-1:0] src_word_q, dst_word_q;
    logic [LEN_W-1:0]       rem;
    logic [LEN_W-1:0]       beats;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   buf_clr, buf_wr, buf_rd;
    logic [31:0]            buf_q;

    assign beats = (rem > LEN_W'(BUF_DEPTH)) ? LEN_W'(BUF_DEPTH) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rem        <= '0;
            beat_cnt   <= '0;
            src_sel_q  <= '0;
            dst_sel_q  <= '0;
            src_word_q <= '0;
            dst_word_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            src_sel_q  <= src_sel;
                            dst_sel_q  <= dst_sel;
                            src_word_q <= src_word;
                            dst_word_q <= dst_word;
                            rem        <= count;
                            state      <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    beat_cnt <= CNT_W'(beats);
                    state    <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    beat_cnt <= beat_cnt - CNT_W'(1);
                    if (beat_cnt == CNT_W'(1)) state <= ST_RD_END;
                end
                ST_RD_END: state <= ST_WR_ADDR;
                ST_WR_ADDR: begin
                    beat_cnt <= CNT_W'(beats);
                    state    <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    beat_cnt <= beat_cnt - CNT_W'(1);
                    if (beat_cnt == CNT_W'(1)) state <= ST_WR_END;
                end
                ST_WR_END: begin
                    src_word_q <= src_word_q + WORD_ADDR_W'(beats);
                    dst_word_q <= dst_word_q + WORD_ADDR_W'(beats);
                    rem        <= rem - beats;
                    state      <= (rem == beats) ? ST_DONE : ST_RD_ADDR;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The target presents word k one cycle after beat k, so the first read
    // cycle has nothing to capture and RD_END captures the final word.
    assign buf_clr = (state == ST_RD_ADDR);
    assign buf_wr  = ((state == ST_RD_DATA) && (beat_cnt != CNT_W'(beats)))
                   || (state == ST_RD_END);
    assign buf_rd  = (state == ST_WR_DATA);

    dma_stage_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (Data),
        .rd_en   (buf_rd),
        .rd_data (buf_q)
    );

    always_comb begin
        bus.Frame   = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.Address = '0;
        case (state)
            ST_RD_ADDR: begin
                bus.Address = addr_phase(src_word_q, src_sel_q);
                bus.read    = 1'b1;
            end
            ST_WR_ADDR: begin
                bus.Address = addr_phase(dst_word_q, dst_sel_q);
                bus.write   = 1'b1;
            end
            ST_RD_DATA, ST_WR_DATA: bus.Frame = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign bus.Ready = busy;
    assign Data      = (state == ST_WR_DATA) ? buf_q : 'z;

`ifdef DMA_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if (state == ST_WR_DATA) begin
            checksum <= checksum + buf_q;
        end
    end
`endif

endmodule

// File: doc/dma_bus_master.md
Name: dma_bus_master

Overview:
- Bus-master side of the shared Frame/Ready/Address/Data bus. It copies a block of 32-bit words from a source target to a destination target, for example memory to memory.
- Drives the address phase and data phases that the memory target decodes. The target is selected by Address[2:0]; the word address is Address[31:3].
- Words are staged in a small internal buffer. The transfer runs as alternating read bursts and write bursts of at most BUF_DEPTH words.

Parameters:
- BUF_DEPTH, 4, staging buffer depth in words; also the maximum burst length.
- LEN_W, 8, width of the word-count input.

Ports:
- clk  in  1  bus clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- src_sel  in  3  source target code, driven on Address[2:0] (memory = 3'b010).
- src_word  in  29  source start word address.
- dst_sel  in  3  destination target code.
- dst_word  in  29  destination start word address.
- count  in  LEN_W  number of words to transfer.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- Frame  out  1  data-phase qualifier.
- Ready  out  1  master ready; held at 1 whenever busy.
- read  out  1  read command, valid in the address phase.
- write  out  1  write command, valid in the address phase.
- Address  out  32  {word[28:0], sel[2:0]} in the address phase; 0 otherwise.
- Data  inout  32  driven only in WR_DATA; high-Z otherwise.

Behaviour:
- Reset values: Frame=0, Ready=0, read=0, write=0, Address=0, busy=0, done=0, Data=Z, state=IDLE. Buffer pointers and remaining count are cleared.
- Reset mid-transfer: the bus is released on the next posedge and any partial data is discarded.
- States: IDLE, RD_ADDR, RD_DATA, RD_END, WR_ADDR, WR_DATA, WR_END, DONE.
- IDLE: on start with count==0, go to DONE (no bus activity). On start with count>0, latch all inputs, set rem=count, and go to RD_ADDR. start while busy is ignored.
- Burst length: beats = min(rem, BUF_DEPTH).
- RD_ADDR (1 cycle): Address={src_word, src_sel}, read=1, write=0, Frame=0. Next state is RD_DATA.
- RD_DATA (beats cycles): Frame=1, Ready=1.
  - The target registers word k on the posedge ending data cycle k.
  - The master captures Data into buf[k-1] on the posedge ending cycle k+1, so capture lags the beat by one cycle.
  - After beats cycles, go to RD_END.
- RD_END (1 cycle): Frame=0 and read=0. Capture the last word. Next state is WR_ADDR.
- WR_ADDR (1 cycle): Address={dst_word, dst_sel}, write=1, read=0, Frame=0.
- WR_DATA (beats cycles): Frame=1 and Data=buf[k]. The target writes on each posedge where Frame=1.
- WR_END (1 cycle): Frame=0 and Data=Z.
  - Update src_word += beats, dst_word += beats, and rem -= beats.
  - If rem>0, go to RD_ADDR; otherwise go to DONE.
- DONE (1 cycle): done=1 and busy drops in the same cycle. Return to IDLE.
- Word addresses wrap modulo 2^29. Select codes never change during a transfer.
- Data is never driven in the same cycle the target may drive it. RD_END and WR_ADDR give a guaranteed turnaround.
- Latency for N words: sum over chunks of (2*beats + 4) cycles, plus 1 for DONE.

Optional Feature:
- Macro: DMA_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (32 bits), the 32-bit wrap-around sum of every word written in WR_DATA.
  - checksum clears on an accepted start and on rst.
  - Valid when done pulses; holds until the next start.
- Undefined: the port and the adder are absent. Bus timing is identical either way.

Decomposition:
- Package dma_pkg holds:
  - state enum dma_state_t;
  - target select constants DEV_MEM=3'b010 and DEV_IO=3'b001;
  - ADDR_SEL_W=3 and WORD_ADDR_W=29.
- One sub-module, dma_stage_buf: a BUF_DEPTH x 32 register file with write pointer and read pointer, both reset at each burst start.

Test Plan:
- Single-word copy: count=1, src 3'b010/word 0 holding 1, dst 3'b010/word 8.
  - Expect: address phase Address=0x02, Frame high 1 cycle, then write address 0x42; memory word 8 == 1.
  - Expect: done after 7 cycles.
- Full burst: count=4, memory words 0..3 = {1,2,2,3}, dst word 16.
  - Expect: Frame high exactly 4 cycles per phase; words 16..19 == {1,2,2,3}; done pulse width is 1.
- Chunking: count=6 with BUF_DEPTH=4.
  - Expect: two read/write burst pairs of 4 then 2; second read Address word = src+4; all 6 words copied in order.
- count=0: start.
  - Expect: done one cycle later; Frame, read and write never assert.
- Reset mid-WR_DATA: assert rst at beat 2.
  - Expect: next posedge Frame=0, Data=Z, busy=0; a subsequent start with count=2 completes normally.
- With DMA_CHECKSUM_EN: copy {5,4,2}.
  - Expect: checksum==11 at done; a start issued while busy is ignored and leaves checksum unchanged.
